// File: rtl/arb_pkg.sv
// Shared types for the arbiter request port: requester count, burst limits, FSM states, command payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  localparam int NREQ      = 8;
  localparam int MAX_BEATS = 8;
  localparam int LEN_W     = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BURST,
    ST_RELEASE
  } arb_port_state_t;

  // One queued burst: start byte address and beats-minus-one.
  typedef struct packed {
    logic [31:0]      adr;
    logic [LEN_W-1:0] len;
  } cmd_t;

endpackage

// File: rtl/arb_cmd_fifo.sv
// Synchronous command FIFO holding {adr,len} burst descriptors, DEPTH entries (power of two).
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: full blocks pushes (dropped), empty blocks pops; push and pop may share a cycle.
// Ports: clk/rst_n; push, push_dat, full; pop, head, empty.
module arb_cmd_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_dat,
  output logic full,
  input  logic pop,
  output cmd_t head,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/arb_req_port.sv
// Arbiter requester port: queues burst commands, requests/locks the bus, walks beats with a watchdog.
// Latency: command visible as req_o two cycles after acceptance; bus_cyc_o one cycle after grant.
// Backpressure: cmd_ready_o low while the command FIFO is full; bus beats advance only on bus_ack_i.
// Ports: cmd_* command intake; req_o/lock_o/sel_i arbiter handshake; bus_* burst master; done_o/err_o pulses.
module arb_req_port
  import arb_pkg::*;
#(
  parameter int ID    = 0,
  parameter int DEPTH = 4,
  parameter int TMO   = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [31:0]     cmd_adr_i,
  input  logic [2:0]      cmd_len_i,
  output logic [NREQ-1:0] req_o,
  output logic [NREQ-1:0] lock_o,
  input  logic [NREQ-1:0] sel_i,
  output logic            bus_cyc_o,
  output logic [31:0]     bus_adr_o,
  input  logic            bus_ack_i,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [NREQ-1:0] ID_BIT = NREQ'(1) << ID;
  localparam int              WDOG_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TMO - 1);

  arb_port_state_t  state;
  logic [LEN_W-1:0] cnt;
  logic [WDOG_W-1:0] wdog;
  cmd_t             push_dat;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             grant;
  logic             in_burst;
  logic             active;
  logic             last_ack;
  logic             tmo_hit;
  logic             abort;
  logic             pop;
  logic             unused_sel;

  // Grant bits of the other requesters are not ours to act on.
  assign unused_sel = ^sel_i;

  assign push_dat    = '{adr: cmd_adr_i, len: cmd_len_i};
  assign cmd_ready_o = !fifo_full;

  arb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid_i),
    .push_dat (push_dat),
    .full     (fifo_full),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty)
  );

  assign grant    = sel_i[ID];
  assign in_burst = (state == ST_BURST);
  assign active   = (state == ST_REQ) || in_burst;
  assign last_ack = in_burst && bus_ack_i && (cnt == '0);
  // TMO-th consecutive burst cycle with no ack.
  assign tmo_hit  = in_burst && !bus_ack_i && (wdog == WDOG_LAST);
  // A completing final beat wins over a simultaneous grant loss.
  assign abort    = in_burst && !last_ack && (!grant || tmo_hit);
  // REQ is only entered with a non-empty FIFO, so the head is valid here.
  assign pop      = (state == ST_REQ) && grant;

  assign req_o  = active ? ID_BIT : '0;
  // Combinational so the lock is up in the very cycle the grant first appears,
  // and drops in the cycle the bus is being let go.
  assign lock_o = (grant && active && !last_ack && !abort) ? ID_BIT : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wdog      <= '0;
      bus_cyc_o <= 1'b0;
      bus_adr_o <= '0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_REQ;
        end
        ST_REQ: begin
          if (grant) begin
            state     <= ST_BURST;
            cnt       <= head.len;
            bus_adr_o <= head.adr;
            bus_cyc_o <= 1'b1;
            wdog      <= '0;
          end
        end
        ST_BURST: begin
          if (last_ack) begin
            done_o    <= 1'b1;
            bus_cyc_o <= 1'b0;
            wdog      <= '0;
            state     <= ST_RELEASE;
          end else if (abort) begin
            // Remaining beats of this burst are discarded.
            err_o     <= 1'b1;
            bus_cyc_o <= 1'b0;
            cnt       <= '0;
            wdog      <= '0;
            state     <= ST_RELEASE;
          end else if (bus_ack_i) begin
            cnt       <= cnt - LEN_W'(1);
            bus_adr_o <= bus_adr_o + 32'd4;
            wdog      <= '0;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        ST_RELEASE: begin
          // Stay off the arbiter for one enabled arbiter cycle so it rotates.
          if (ce) state <= fifo_empty ? ST_IDLE : ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_req_port.sv
// Self-checking bench for arb_req_port (ID=3, DEPTH=4, TMO=255) with a burst scoreboard.
// Latency: n/a.
// Backpressure: exercises FIFO full, ce-gated release and grant loss.
module tb_arb_req_port;

  localparam int         ID  = 3;
  localparam logic [7:0] IDB = 8'h08;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_adr_i;
  logic [2:0]  cmd_len_i;
  logic [7:0]  req_o;
  logic [7:0]  lock_o;
  logic [7:0]  sel_i;
  logic        bus_cyc_o;
  logic [31:0] bus_adr_o;
  logic        bus_ack_i;
  logic        done_o;
  logic        err_o;

  arb_req_port #(.ID(ID), .DEPTH(4), .TMO(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_len_i   (cmd_len_i),
    .req_o       (req_o),
    .lock_o      (lock_o),
    .sel_i       (sel_i),
    .bus_cyc_o   (bus_cyc_o),
    .bus_adr_o   (bus_adr_o),
    .bus_ack_i   (bus_ack_i),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    int          len;
  } exp_cmd_t;

  exp_cmd_t    exp_q[$];
  exp_cmd_t    cur;
  logic [31:0] cur_adr;
  int          beats;
  int          done_cnt;
  int          err_cnt;
  logic        prev_cyc;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one command for one cycle; only commands the DUT will take go to the scoreboard.
  task automatic push_cmd(input logic [31:0] a, input int l);
    exp_cmd_t e;
    cmd_valid_i = 1'b1;
    cmd_adr_i   = a;
    cmd_len_i   = 3'(l);
    if (cmd_ready_o) begin
      e.adr = a;
      e.len = l;
      exp_q.push_back(e);
    end
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int found;
    found = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done_o) begin
        found = 1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_cyc(input string tag, input int bound);
    int found;
    found = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus_cyc_o) begin
        found = 1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Scoreboard: each new bus cycle takes the oldest accepted command and checks its beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cyc = 1'b0;
    end else begin
      chk("id_mask", {16'h0, req_o & ~IDB, lock_o & ~IDB}, 32'd0);
      if (bus_cyc_o && !prev_cyc) begin
        chk("burst_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur     = exp_q.pop_front();
          cur_adr = cur.adr;
          beats   = 0;
        end
      end
      if (bus_cyc_o && bus_ack_i) begin
        chk("beat_adr", bus_adr_o, cur_adr);
        cur_adr = cur_adr + 32'd4;
        beats++;
      end
      if (done_o) begin
        done_cnt++;
        chk("done_beats", 32'(beats), 32'(cur.len + 1));
      end
      if (err_o) err_cnt++;
      prev_cyc = bus_cyc_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_d;
    int base_e;
    int n;
    tests = 0; fails = 0; done_cnt = 0; err_cnt = 0;
    beats = 0; cur_adr = '0; prev_cyc = 1'b0;
    cur.adr = '0; cur.len = 0;
    rst_n = 1'b0; ce = 1'b0; cmd_valid_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    sel_i = '0; bus_ack_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req",   32'(req_o), 32'd0);
    chk("rst_lock",  32'(lock_o), 32'd0);
    chk("rst_cyc",   32'(bus_cyc_o), 32'd0);
    chk("rst_adr",   bus_adr_o, 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    rst_n = 1'b1; ce = 1'b1;
    step();

    // Basic 4-beat burst with ack every cycle
    push_cmd(32'h0000_1000, 3);
    step();
    chk("t1_req", 32'(req_o), 32'(IDB));
    chk("t1_lock_pre", 32'(lock_o), 32'd0);
    sel_i = IDB; bus_ack_i = 1'b1;
    #1;
    chk("t1_lock_grant", 32'(lock_o), 32'(IDB));
    chk("t1_cyc_grant", 32'(bus_cyc_o), 32'd0);
    step();
    chk("t1_lock_beat", 32'(lock_o), 32'(IDB));
    chk("t1_cyc", 32'(bus_cyc_o), 32'd1);
    step(); step(); step();
    chk("t1_lock_last", 32'(lock_o), 32'd0);
    chk("t1_cyc_last", 32'(bus_cyc_o), 32'd1);
    wait_done("t1_done", 4);
    chk("t1_rel_req", 32'(req_o), 32'd0);
    chk("t1_rel_cyc", 32'(bus_cyc_o), 32'd0);
    sel_i = '0; bus_ack_i = 1'b0;
    repeat (3) step();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Fill the FIFO, fifth command dropped, four bursts in order (one wraps)
    push_cmd(32'h2000_0000, 0);
    push_cmd(32'h2100_0000, 7);
    push_cmd(32'hFFFF_FFF8, 2);
    push_cmd(32'h2300_0010, 5);
    chk("t2_full", 32'(cmd_ready_o), 32'd0);
    push_cmd(32'hDEAD_0000, 1);
    chk("t2_req", 32'(req_o), 32'(IDB));
    base_d = done_cnt;
    sel_i = IDB; bus_ack_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done_cnt == base_d + 4) break;
    end
    repeat (5) step();
    sel_i = '0; bus_ack_i = 1'b0;
    chk("t2_done4", 32'(done_cnt - base_d), 32'd4);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_ready", 32'(cmd_ready_o), 32'd1);
    chk("t2_cyc_idle", 32'(bus_cyc_o), 32'd0);

    // Watchdog timeout with no acks
    base_d = done_cnt; base_e = err_cnt;
    sel_i = IDB; bus_ack_i = 1'b0;
    push_cmd(32'h0000_2000, 0);
    wait_cyc("t3_start", 10);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!bus_cyc_o) break;
      n++;
    end
    chk("t3_tmo_cycles", 32'(n), 32'd255);
    chk("t3_err", 32'(err_o), 32'd1);
    chk("t3_lock", 32'(lock_o), 32'd0);
    chk("t3_cyc", 32'(bus_cyc_o), 32'd0);
    chk("t3_req", 32'(req_o), 32'd0);
    step();
    chk("t3_err_pulse", 32'(err_o), 32'd0);
    sel_i = '0;
    repeat (2) step();
    chk("t3_err_cnt", 32'(err_cnt - base_e), 32'd1);
    chk("t3_no_done", 32'(done_cnt - base_d), 32'd0);

    // Grant lost mid-burst, next command re-requests
    base_e = err_cnt;
    sel_i = IDB; bus_ack_i = 1'b1;
    push_cmd(32'h0000_3000, 7);
    push_cmd(32'h0000_4000, 1);
    wait_cyc("t4_start", 10);
    step(); step();
    sel_i = '0; bus_ack_i = 1'b0;
    #1;
    chk("t4_lock_drop", 32'(lock_o), 32'd0);
    step();
    chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_cyc", 32'(bus_cyc_o), 32'd0);
    chk("t4_rel_req", 32'(req_o), 32'd0);
    step();
    chk("t4_rereq", 32'(req_o), 32'(IDB));
    sel_i = IDB; bus_ack_i = 1'b1;
    wait_done("t4_done", 20);
    repeat (2) step();
    sel_i = '0; bus_ack_i = 1'b0;
    chk("t4_err_cnt", 32'(err_cnt - base_e), 32'd1);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Release held while ce=0; push and pop share the grant cycle
    repeat (3) step();
    base_d = done_cnt;
    ce = 1'b0; sel_i = IDB; bus_ack_i = 1'b1;
    push_cmd(32'h0000_5000, 0);
    step();
    chk("t5_req", 32'(req_o), 32'(IDB));
    push_cmd(32'h0000_6000, 0);
    chk("t5_cyc", 32'(bus_cyc_o), 32'd1);
    step();
    chk("t5_done", 32'(done_o), 32'd1);
    chk("t5_rel_req0", 32'(req_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_rel_req_ce0", 32'(req_o), 32'd0);
    end
    step();
    ce = 1'b1;
    #1;
    chk("t5_rel_req_ce1", 32'(req_o), 32'd0);
    step();
    chk("t5_rereq", 32'(req_o), 32'(IDB));
    wait_done("t5_done_b", 10);
    repeat (2) step();
    sel_i = '0; bus_ack_i = 1'b0;
    chk("t5_done_cnt", 32'(done_cnt - base_d), 32'd2);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-burst
    repeat (3) step();
    sel_i = IDB; bus_ack_i = 1'b1;
    push_cmd(32'h0000_7000, 7);
    wait_cyc("t6_start", 10);
    step(); step();
    base_d = done_cnt; base_e = err_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_req",   32'(req_o), 32'd0);
    chk("t6_lock",  32'(lock_o), 32'd0);
    chk("t6_cyc",   32'(bus_cyc_o), 32'd0);
    chk("t6_adr",   bus_adr_o, 32'd0);
    chk("t6_done",  32'(done_o), 32'd0);
    chk("t6_err",   32'(err_o), 32'd0);
    chk("t6_ready", 32'(cmd_ready_o), 32'd1);
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("t6_no_done", 32'(done_cnt - base_d), 32'd0);
    chk("t6_no_err",  32'(err_cnt - base_e), 32'd0);
    chk("t6_idle_cyc", 32'(bus_cyc_o), 32'd0);
    chk("t6_idle_req", 32'(req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
